// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the
// instruction-fetch port and the load/store data port of the multi-cycle core.
// One access runs at a time (IDLE -> ACCESS -> DONE). Ties go round-robin.
// Each access ends with a one-cycle done pulse on the port that was granted.

module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic       PORT_FETCH = 1'b0;
   localparam logic       PORT_DATA  = 1'b1;
   // The counter runs MEM_LAT-1 down to 0, so the capture cycle is the one with cnt==0.
   localparam logic [3:0] CNT_LOAD   = 4'(MEM_LAT - 1);

   state_t      state;
   state_t      state_next;
   logic        gnt_port;
   logic        gnt_we;
   logic        last_gnt;
   logic [3:0]  cnt;
   logic        any_req;
   logic        winner;

   // Pick the port to serve: a lone request wins outright, a tie goes to the port not served last.
   always_comb begin
      any_req = if_req | d_req;
      winner  = PORT_FETCH;
      if (if_req && d_req) begin
         winner = ~last_gnt;
      end else if (d_req) begin
         winner = PORT_DATA;
      end
   end

   // State register; reset drops any in-flight access so no done pulse follows it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus the strobes and done pulses, all decoded from the state so reset clears them at once.
   always_comb begin
      state_next = state;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      if_done    = 1'b0;
      d_done     = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (any_req) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            mem_read  = ~gnt_we;
            mem_write = gnt_we && (cnt == CNT_LOAD);
            if (cnt == 4'd0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if_done    = (gnt_port == PORT_FETCH);
            d_done     = (gnt_port == PORT_DATA);
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Grant bookkeeping, latched command, latency counter and the per-port read data registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_port  <= PORT_FETCH;
         gnt_we    <= 1'b0;
         last_gnt  <= PORT_DATA;
         cnt       <= 4'd0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_port  <= winner;
                  last_gnt  <= winner;
                  gnt_we    <= (winner == PORT_DATA) && d_we;
                  mem_addr  <= (winner == PORT_DATA) ? d_addr : if_addr;
                  mem_wdata <= (winner == PORT_DATA) ? d_wdata : '0;
                  cnt       <= CNT_LOAD;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (!gnt_we) begin
                  if (gnt_port == PORT_DATA) begin
                     d_rdata <= mem_rdata;
                  end else begin
                     if_rdata <= mem_rdata;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed traffic on both ports of a MEM_LAT=2 arbiter,
// a transaction-level predictor feeding a scoreboard, and two extra instances with
// MEM_LAT=1 and MEM_LAT=4 for latency checks.

module tb_mem_port_arbiter;

   localparam int          LAT     = 2;
   localparam logic [31:0] AUX_KEY = 32'hC0DE_0000;

   logic        clk;
   logic        reset;
   logic        aux_reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_read;
   logic        mem_write;
   logic        busy;

   logic        a_dreq    [2];
   logic [31:0] a_daddr   [2];
   logic        a_ddone   [2];
   logic [31:0] a_drdata  [2];
   logic [31:0] a_ifrdata [2];
   logic        a_ifdone  [2];
   logic [31:0] a_maddr   [2];
   logic [31:0] a_mwdata  [2];
   logic [31:0] a_mrdata  [2];
   logic        a_mread   [2];
   logic        a_mwrite  [2];
   logic        a_busy    [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit pred_en = 0;
   bit chk_en = 0;

   typedef struct {
      int          g;
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mem_model [logic [31:0]];
   bit          m_last = 1'b1;
   int          free_at = 0;
   logic [31:0] m_if_rdata = 32'h0;
   logic [31:0] m_d_rdata = 32'h0;
   int          rd_run = 0;
   int          wr_cycles = 0;
   int          t_start = 0;
   int          if_done_cyc = 0;
   int          d_done_cyc = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) aux1 (
      .clk(clk), .reset(aux_reset),
      .if_req(1'b0), .if_addr(32'h0), .if_rdata(a_ifrdata[0]), .if_done(a_ifdone[0]),
      .d_req(a_dreq[0]), .d_we(1'b0), .d_addr(a_daddr[0]), .d_wdata(32'h0),
      .d_rdata(a_drdata[0]), .d_done(a_ddone[0]),
      .mem_addr(a_maddr[0]), .mem_wdata(a_mwdata[0]), .mem_read(a_mread[0]),
      .mem_write(a_mwrite[0]), .mem_rdata(a_mrdata[0]), .busy(a_busy[0])
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) aux4 (
      .clk(clk), .reset(aux_reset),
      .if_req(1'b0), .if_addr(32'h0), .if_rdata(a_ifrdata[1]), .if_done(a_ifdone[1]),
      .d_req(a_dreq[1]), .d_we(1'b0), .d_addr(a_daddr[1]), .d_wdata(32'h0),
      .d_rdata(a_drdata[1]), .d_done(a_ddone[1]),
      .mem_addr(a_maddr[1]), .mem_wdata(a_mwdata[1]), .mem_read(a_mread[1]),
      .mem_write(a_mwrite[1]), .mem_rdata(a_mrdata[1]), .busy(a_busy[1])
   );

   assign a_mrdata[0] = a_mread[0] ? (a_maddr[0] ^ AUX_KEY) : 32'hFFFF_FFFF;
   assign a_mrdata[1] = a_mread[1] ? (a_maddr[1] ^ AUX_KEY) : 32'hFFFF_FFFF;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle number, read by the predictor and monitor away from the clock edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Unwritten locations hold a value derived from their address.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'h1000 + ($urandom_range(0, 15) << 2);
      return a;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory model: stores writes and only presents true data once a read has been held MEM_LAT cycles.
   initial begin
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_write) begin
            mem_model[mem_addr] = mem_wdata;
            wr_cycles++;
         end
         if (mem_read) rd_run++;
         else rd_run = 0;
         mem_rdata = (mem_read && rd_run == LAT) ? mem_val(mem_addr) : ~mem_val(mem_addr);
      end
   end

   // Predictor: decides each grant from the request lines and pushes the expected transaction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pred_en && cyc >= free_at && (if_req || d_req)) begin
            e.g = cyc;
            if (if_req && d_req) e.port = !m_last;
            else e.port = d_req;
            e.we    = e.port && d_we;
            e.addr  = e.port ? d_addr : if_addr;
            e.wdata = d_wdata;
            e.rdata = mem_val(e.addr);
            m_last  = e.port;
            free_at = cyc + LAT + 2;
            sb.push_back(e);
         end
      end
   end

   // Monitor: compares strobes, busy, done pulses and read data with the front transaction.
   initial begin
      exp_t e;
      bit   xr, xw, xb, xi, xd, fin;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            xr = 0; xw = 0; xb = 0; xi = 0; xd = 0; fin = 0;
            if (sb.size() > 0) begin
               e = sb[0];
               if (cyc > e.g && cyc <= e.g + LAT) begin
                  xb = 1;
                  xr = !e.we;
                  xw = e.we && (cyc == e.g + 1);
               end else if (cyc == e.g + LAT + 1) begin
                  xb = 1;
                  xi = !e.port;
                  xd = e.port;
                  fin = 1;
               end
            end
            check_output("busy", busy, xb);
            check_output("mem_read", mem_read, xr);
            check_output("mem_write", mem_write, xw);
            check_output("if_done", if_done, xi);
            check_output("d_done", d_done, xd);
            if (xr || xw) check_output("mem_addr", mem_addr, e.addr);
            if (xw) check_output("mem_wdata", mem_wdata, e.wdata);
            if (fin) begin
               if (!e.we) begin
                  if (e.port) m_d_rdata = e.rdata;
                  else m_if_rdata = e.rdata;
               end
               void'(sb.pop_front());
            end
            check_output("if_rdata", if_rdata, m_if_rdata);
            check_output("d_rdata", d_rdata, m_d_rdata);
         end
      end
   end

   // Raise the chosen requests together and hold each until its done pulse.
   task automatic apply_stimulus(input logic f, input logic [31:0] fa, input logic d,
                                 input logic dwe, input logic [31:0] da, input logic [31:0] dw);
      bit fp;
      bit dp;
      int n;
      @(posedge clk); #2;
      if_req = f; if_addr = fa;
      d_req = d; d_we = dwe; d_addr = da; d_wdata = dw;
      t_start = cyc;
      fp = f; dp = d; n = 0;
      while ((fp || dp) && n < 40) begin
         @(posedge clk); #2;
         n++;
         if (if_done) begin
            if (fp) if_done_cyc = cyc;
            fp = 0; if_req = 1'b0;
         end
         if (d_done) begin
            if (dp) d_done_cyc = cyc;
            dp = 0; d_req = 1'b0;
         end
      end
      check_output("stim_complete", {30'b0, fp, dp}, 32'h0);
   endtask

   task automatic rand_fetch(input int n);
      int k;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #2;
         if (if_req && if_done) begin
            if ($urandom_range(0, 1) == 0) if_req = 1'b0;
            else if_addr = rand_addr();
         end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1;
            if_addr = rand_addr();
         end
      end
      k = 0;
      while (if_req && k < 60) begin
         @(posedge clk); #2;
         k++;
         if (if_done) if_req = 1'b0;
      end
      check_output("fetch_drain", if_req, 1'b0);
   endtask

   task automatic rand_data(input int n);
      int k;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #2;
         if (d_req && d_done) begin
            if ($urandom_range(0, 1) == 0) d_req = 1'b0;
            else begin
               d_we = 1'($urandom_range(0, 1));
               d_addr = rand_addr();
               d_wdata = $urandom;
            end
         end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1;
            d_we = 1'($urandom_range(0, 1));
            d_addr = rand_addr();
            d_wdata = $urandom;
         end
      end
      k = 0;
      while (d_req && k < 60) begin
         @(posedge clk); #2;
         k++;
         if (d_done) d_req = 1'b0;
      end
      check_output("data_drain", d_req, 1'b0);
   endtask

   // Single load of 0x8C on an auxiliary instance; done must come lat+1 cycles after the request.
   task automatic run_aux(input int i, input int lat);
      int n;
      bit got;
      @(posedge clk); #2;
      a_dreq[i] = 1'b1;
      a_daddr[i] = 32'h8C;
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(posedge clk); #2;
         n++;
         if (a_ddone[i]) got = 1;
      end
      a_dreq[i] = 1'b0;
      check_output($sformatf("t6_latency_lat%0d", lat), n, lat + 1);
      check_output($sformatf("t6_rdata_lat%0d", lat), a_drdata[i], 32'h8C ^ AUX_KEY);
   endtask

   initial begin
      int n;
      int fetch_cnt;
      int fetch_before_d;
      int wr_before;
      bit seen_d;

      reset = 1'b0; aux_reset = 1'b0;
      if_req = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         a_dreq[i] = 1'b0;
         a_daddr[i] = 32'h0;
      end
      mem_model[32'h40] = 32'h2008_000A;

      repeat (2) @(posedge clk);
      #2;
      check_output("rst_busy", busy, 1'b0);
      check_output("rst_mem_read", mem_read, 1'b0);
      check_output("rst_mem_write", mem_write, 1'b0);
      check_output("rst_if_done", if_done, 1'b0);
      check_output("rst_d_done", d_done, 1'b0);
      check_output("rst_mem_addr", mem_addr, 32'h0);
      check_output("rst_mem_wdata", mem_wdata, 32'h0);
      check_output("rst_if_rdata", if_rdata, 32'h0);
      check_output("rst_d_rdata", d_rdata, 32'h0);

      @(negedge clk);
      reset = 1'b1; aux_reset = 1'b1;
      free_at = cyc; pred_en = 1; chk_en = 1;

      $display("[TB] T2: tie after reset, then a second tie");
      apply_stimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
      check_output("t2_first_tie_fetch_first", d_done_cyc - if_done_cyc, LAT + 2);
      apply_stimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h84, 32'h0);
      check_output("t2_second_tie_fetch_first", d_done_cyc - if_done_cyc, LAT + 2);

      $display("[TB] T1: single fetch of 0x40");
      apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
      check_output("t1_latency", if_done_cyc - t_start, LAT + 1);
      check_output("t1_if_rdata", if_rdata, 32'h2008_000A);

      $display("[TB] T3: store 0xDEADBEEF to 0x100");
      wr_before = wr_cycles;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
      check_output("t3_latency", d_done_cyc - t_start, LAT + 1);
      check_output("t3_write_cycles", wr_cycles - wr_before, 1);
      check_output("t3_mem_content", mem_val(32'h100), 32'hDEAD_BEEF);
      check_output("t3_d_rdata_kept", d_rdata, 32'h5A5A_0084);

      $display("[TB] T4: data request during a held fetch");
      @(posedge clk); #2;
      if_req = 1'b1; if_addr = 32'h200;
      @(posedge clk); #2;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      n = 0; fetch_cnt = 0; fetch_before_d = -1; seen_d = 0;
      while (n < 40 && !(seen_d && !if_req)) begin
         @(posedge clk); #2;
         n++;
         if (if_done) begin
            fetch_cnt++;
            if (seen_d) if_req = 1'b0;
         end
         if (d_done) begin
            seen_d = 1;
            fetch_before_d = fetch_cnt;
            d_req = 1'b0;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      check_output("t4_completed", {31'b0, seen_d}, 32'h1);
      check_output("t4_fetches_before_data", fetch_before_d, 1);

      $display("[TB] random traffic on both ports");
      fork
         rand_fetch(400);
         rand_data(400);
      join
      n = 0;
      while (sb.size() > 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check_output("scoreboard_empty", sb.size(), 0);

      $display("[TB] T5: reset during a load");
      @(posedge clk); #2;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      @(posedge clk); #2;
      check_output("t5_read_before_reset", mem_read, 1'b1);
      pred_en = 0; chk_en = 0;
      reset = 1'b0;
      #1;
      check_output("t5_read_drops", mem_read, 1'b0);
      check_output("t5_busy_drops", busy, 1'b0);
      d_req = 1'b0;
      sb.delete();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         check_output("t5_no_done", d_done, 1'b0);
      end
      @(negedge clk);
      reset = 1'b1;
      m_last = 1'b1; m_if_rdata = 32'h0; m_d_rdata = 32'h0; free_at = cyc;
      @(posedge clk); #2;
      check_output("t5_busy", busy, 1'b0);
      check_output("t5_mem_read", mem_read, 1'b0);
      check_output("t5_mem_write", mem_write, 1'b0);
      check_output("t5_if_done", if_done, 1'b0);
      check_output("t5_d_done", d_done, 1'b0);
      check_output("t5_mem_addr", mem_addr, 32'h0);
      check_output("t5_mem_wdata", mem_wdata, 32'h0);
      check_output("t5_if_rdata", if_rdata, 32'h0);
      check_output("t5_d_rdata", d_rdata, 32'h0);
      pred_en = 1; chk_en = 1;
      apply_stimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h88, 32'h0);
      check_output("t5_tie_after_reset_fetch_first", d_done_cyc - if_done_cyc, LAT + 2);

      $display("[TB] T6: MEM_LAT=1 and MEM_LAT=4 loads");
      run_aux(0, 1);
      run_aux(1, 4);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Backstop so the run always ends even if a wait above were never satisfied.
   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
